gravity_tick_gen: RTL

GRAVITY_TICK_GEN -- requirements
Module: gravity_tick_gen

---
 rtl/gravity_tick_gen.sv | 90 +++++++++
 1 files changed

// File: rtl/gravity_tick_gen.sv
// gravity_tick_gen: periodic "fall step" tick generator.
//
// A WIDTH-bit counter runs 0..period_cur-1 while en is high. On the edge
// after the terminal count a one-cycle registered tick is produced. With
// GRAVITY_TICK_ACCEL_EN defined, each tick also shortens the period by STEP,
// floored at MIN_PERIOD. Without the macro the period is fixed at
// START_PERIOD. restart (synchronous) and reset (asynchronous) both return
// the block to its start state; restart beats a coincident terminal count.
//
// Legal parameters: 1 <= MIN_PERIOD <= START_PERIOD <= 2**WIDTH-1.
module gravity_tick_gen #(
    parameter int WIDTH        = 12,
    parameter int START_PERIOD = 3000,
    parameter int MIN_PERIOD   = 500,
    parameter int STEP         = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    output logic             tick,
    output logic [WIDTH-1:0] period_cur,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] START_P = WIDTH'(START_PERIOD);
    localparam logic [WIDTH-1:0] MIN_P   = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic             terminal;

    // Terminal count only matters while counting is enabled.
    assign terminal = en && (cnt == (period_cur - ONE));

    // Cycle counter and registered tick pulse; restart has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (terminal) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else if (en) begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
        end
    end

`ifdef GRAVITY_TICK_ACCEL_EN
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] period_next;

    // Shortened period: subtract one bit wider so an underflow shows up as a
    // set MSB instead of wrapping, then clamp to the floor.
    always_comb begin
        diff        = {1'b0, period_cur} - STEP_W;
        period_next = diff[WIDTH-1:0];
        if (diff[WIDTH] || (diff[WIDTH-1:0] < MIN_P)) begin
            period_next = MIN_P;
        end
    end

    // Period register: reloads on restart, shortens on every tick-producing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cur <= START_P;
        end else if (restart) begin
            period_cur <= START_P;
        end else if (terminal) begin
            period_cur <= period_next;
        end
    end

    // Floor flag decoded straight from the period register.
    assign at_min = (period_cur == MIN_P);
`else
    // Fixed-period build: the period never changes, so the floor flag is a constant.
    assign period_cur = START_P;
    assign at_min     = (START_P == MIN_P);
`endif

endmodule
